mem_stage: RTL and testbench

Pipeline memory stage for the five-stage RV32I core, directly downstream of the execute stage. Consumes the EX/MEM register contents (ALU result as address, forwarded store data, memory control), runs a request/acknowledge transaction on the data-memory bus, aligns and extends load data, and owns the MEM/WB pipeline register. It stalls the front of the pipeline while a transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 30 +++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_stage_load_align.sv | 34 +++
 rtl/mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage and its load aligner.
// Contents: access size encoding, LSU state encoding, base byte-lane masks,
// and a helper that flags misaligned accesses.
package mem_definitions;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  // Base lane masks for lane 0; shifted up by the byte offset where needed.
  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  function automatic logic is_misaligned(mem_size_t size, logic [1:0] addr_lo);
    case (size)
      MEM_H:   return addr_lo[0];
      MEM_W:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus.
// master (LSU):  d_req, d_we, d_addr[31:0], d_be[3:0], d_wdata[31:0] out;
//                d_ack, d_rdata[31:0] in.
// slave (memory): the reverse.
interface mem_stage_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (
    output d_req, d_we, d_addr, d_be, d_wdata,
    input  d_ack, d_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_be, d_wdata,
    output d_ack, d_rdata
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half out of the read word
// and sign- or zero-extends it to 32 bits. Purely combinational.
// Ports: rdata_i[31:0] read word, addr_lo_i[1:0] byte offset, size_i access
//        size, unsigned_i zero-extend, data_o[31:0] aligned result.
module load_align
  import mem_definitions::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  mem_size_t   size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      MEM_B:   data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      MEM_H:   data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: runs data-memory transactions for loads/stores from
// the EX/MEM register, aligns load data and owns the MEM/WB register.
// Ports: clk, rst_n; m_* EX/MEM inputs, m_stall_o front-end hold;
//        dbus data-memory master; w_* MEM/WB register outputs.
//
// state | meaning
// IDLE  | no transaction; non-memory/misaligned ops retire in one cycle
// BUSY  | request outstanding on dbus, waiting for d_ack
module mem_stage
  import mem_definitions::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_valid_i,
  input  logic               m_mem_read_i,
  input  logic               m_mem_write_i,
  input  mem_size_t          m_mem_size_i,
  input  logic               m_mem_unsigned_i,
  input  logic [31:0]        m_alu_out_i,
  input  logic [31:0]        m_mem_data_i,
  input  logic [4:0]         m_rd_i,
  input  logic               m_reg_write_i,
  output logic               m_stall_o,
  mem_stage_if.master        dbus,
  output logic [31:0]        w_data_o,
  output logic [4:0]         w_rd_o,
  output logic               w_reg_write_o,
  output logic               w_valid_o,
  output logic               w_misaligned_o
);

  lsu_state_t  state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  mem_size_t   size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_wr_q, load_wr_d;
  logic [31:0] w_data_q, w_data_d;
  logic [4:0]  w_rd_q, w_rd_d;
  logic        w_rw_q, w_rw_d, w_valid_q, w_valid_d, w_mis_q, w_mis_d;

  logic        mem_op, mis, start, stall;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, load_data;

  assign mem_op = m_valid_i & (m_mem_read_i | m_mem_write_i);
  assign mis    = mem_op & is_misaligned(m_mem_size_i, m_alu_out_i[1:0]);
  assign start  = (state_q == IDLE) & mem_op & ~mis;

  always_comb begin
    case (m_mem_size_i)
      MEM_B: begin
        st_be    = LANE_B << m_alu_out_i[1:0];
        st_wdata = {4{m_mem_data_i[7:0]}};
      end
      MEM_H: begin
        st_be    = m_alu_out_i[1] ? (LANE_H << 2) : LANE_H;
        st_wdata = {2{m_mem_data_i[15:0]}};
      end
      default: begin
        st_be    = LANE_W;
        st_wdata = m_mem_data_i;
      end
    endcase
  end

  load_align u_load_align (
    .rdata_i    (dbus.d_rdata),
    .addr_lo_i  (addr_lo_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    addr_lo_d = addr_lo_q;
    size_d    = size_q;
    uns_d     = uns_q;
    rd_d      = rd_q;
    load_wr_d = load_wr_q;
    w_data_d  = w_data_q;
    w_rd_d    = w_rd_q;
    w_rw_d    = 1'b0;
    w_valid_d = 1'b0;
    w_mis_d   = 1'b0;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          stall     = 1'b1;
          req_d     = 1'b1;
          we_d      = m_mem_write_i;
          addr_d    = {m_alu_out_i[31:2], 2'b00};
          be_d      = st_be;
          wdata_d   = st_wdata;
          addr_lo_d = m_alu_out_i[1:0];
          size_d    = m_mem_size_i;
          uns_d     = m_mem_unsigned_i;
          rd_d      = m_rd_i;
          // A write takes priority if both strobes are set; it never writes rd.
          load_wr_d = m_mem_read_i & ~m_mem_write_i & m_reg_write_i;
        end else if (mis) begin
          w_valid_d = 1'b1;
          w_mis_d   = 1'b1;
          w_data_d  = m_alu_out_i;
          w_rd_d    = m_rd_i;
        end else if (m_valid_i) begin
          w_valid_d = 1'b1;
          w_rw_d    = m_reg_write_i;
          w_data_d  = m_alu_out_i;
          w_rd_d    = m_rd_i;
        end
      end
      BUSY: begin
        stall = ~dbus.d_ack;
        if (dbus.d_ack) begin
          state_d   = IDLE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          w_valid_d = 1'b1;
          w_rw_d    = load_wr_q;
          w_data_d  = load_data;
          w_rd_d    = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      addr_lo_q <= '0;
      size_q    <= MEM_B;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      load_wr_q <= 1'b0;
      w_data_q  <= '0;
      w_rd_q    <= '0;
      w_rw_q    <= 1'b0;
      w_valid_q <= 1'b0;
      w_mis_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rd_q      <= rd_d;
      load_wr_q <= load_wr_d;
      w_data_q  <= w_data_d;
      w_rd_q    <= w_rd_d;
      w_rw_q    <= w_rw_d;
      w_valid_q <= w_valid_d;
      w_mis_q   <= w_mis_d;
    end
  end

  // Stall is combinational from live inputs; hold it low while in reset.
  assign m_stall_o      = stall & rst_n;
  assign dbus.d_req     = req_q;
  assign dbus.d_we      = we_q;
  assign dbus.d_addr    = addr_q;
  assign dbus.d_be      = be_q;
  assign dbus.d_wdata   = wdata_q;
  assign w_data_o       = w_data_q;
  assign w_rd_o         = w_rd_q;
  assign w_reg_write_o  = w_rw_q;
  assign w_valid_o      = w_valid_q;
  assign w_misaligned_o = w_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mem_definitions::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_valid, m_mem_read, m_mem_write, m_mem_unsigned, m_reg_write;
  mem_size_t   m_mem_size;
  logic [31:0] m_alu_out, m_mem_data;
  logic [4:0]  m_rd;
  logic        m_stall;
  logic [31:0] w_data;
  logic [4:0]  w_rd;
  logic        w_reg_write, w_valid, w_misaligned;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .m_valid_i        (m_valid),
    .m_mem_read_i     (m_mem_read),
    .m_mem_write_i    (m_mem_write),
    .m_mem_size_i     (m_mem_size),
    .m_mem_unsigned_i (m_mem_unsigned),
    .m_alu_out_i      (m_alu_out),
    .m_mem_data_i     (m_mem_data),
    .m_rd_i           (m_rd),
    .m_reg_write_i    (m_reg_write),
    .m_stall_o        (m_stall),
    .dbus             (bus),
    .w_data_o         (w_data),
    .w_rd_o           (w_rd),
    .w_reg_write_o    (w_reg_write),
    .w_valid_o        (w_valid),
    .w_misaligned_o   (w_misaligned)
  );

  typedef struct {
    string       name;
    logic        rd, wr;
    mem_size_t   size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic [4:0]  rdn;
    logic [31:0] rdata;
    int          ack_lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_w;
    logic        exp_rw;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } res_t;

  res_t sb[$];
  vec_t vecs[13];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(string nm, logic rd, logic wr, mem_size_t sz, logic uns,
                              logic [31:0] a, logic [31:0] wd, logic [4:0] rdn,
                              logic [31:0] rdata, int lat, logic req, logic [31:0] ea,
                              logic [3:0] ebe, logic [31:0] ewd, logic [31:0] ew,
                              logic erw, logic emis);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.size = sz; v.uns = uns;
    v.addr = a; v.wdata = wd; v.rdn = rdn; v.rdata = rdata; v.ack_lat = lat;
    v.exp_req = req; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
    v.exp_w = ew; v.exp_rw = erw; v.exp_mis = emis;
    return v;
  endfunction

  // Writeback scoreboard: every retired slot must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!w_valid) begin
        chk("bubble_rw_mis", {30'd0, w_reg_write, w_misaligned}, 32'd0);
      end else if (sb.size() == 0) begin
        chk("unexpected_wb", {31'd0, w_valid}, 32'd0);
      end else begin
        res_t r;
        r = sb.pop_front();
        chk("wb_reg_write", {31'd0, w_reg_write}, {31'd0, r.rw});
        chk("wb_misaligned", {31'd0, w_misaligned}, {31'd0, r.mis});
        if (!r.mis) chk("wb_rd", {27'd0, w_rd}, {27'd0, r.rd});
        if (r.rw) chk("wb_data", w_data, r.data);
      end
    end
  end

  task automatic apply(vec_t v);
    int   stalls = 0;
    int   busy = 0;
    logic st;
    logic seen = 1'b0;
    logic done = 1'b0;
    res_t r;
    @(negedge clk);
    m_valid = 1'b1; m_mem_read = v.rd; m_mem_write = v.wr; m_mem_size = v.size;
    m_mem_unsigned = v.uns; m_alu_out = v.addr; m_mem_data = v.wdata;
    m_rd = v.rdn; m_reg_write = 1'b1; bus.d_ack = 1'b0;
    r.data = v.exp_w; r.rd = v.rdn; r.rw = v.exp_rw; r.mis = v.exp_mis;
    sb.push_back(r);
    for (int i = 0; i < 20; i++) begin
      #1;
      st = m_stall;
      if (st) stalls++;
      @(posedge clk);
      if (!st) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      chk({v.name, " d_req_busy"}, {31'd0, bus.d_req}, 32'd1);
      if (!seen) begin
        seen = 1'b1;
        chk({v.name, " d_we"}, {31'd0, bus.d_we}, {31'd0, v.wr});
        chk({v.name, " d_addr"}, bus.d_addr, v.exp_addr);
        if (v.wr) begin
          chk({v.name, " d_be"}, {28'd0, bus.d_be}, {28'd0, v.exp_be});
          chk({v.name, " d_wdata"}, bus.d_wdata, v.exp_wdata);
        end
      end
      busy++;
      if (busy == v.ack_lat) begin
        bus.d_ack = 1'b1;
        bus.d_rdata = v.rdata;
      end
    end
    #1;
    chk({v.name, " completed"}, {31'd0, done}, 32'd1);
    chk({v.name, " requested"}, {31'd0, seen}, {31'd0, v.exp_req});
    chk({v.name, " stall_cycles"}, stalls, v.exp_req ? v.ack_lat : 0);
    chk({v.name, " d_req_after"}, {31'd0, bus.d_req}, 32'd0);
    bus.d_ack = 1'b0;
    bus.d_rdata = 32'h0;
    m_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk("sw",     0, 1, MEM_W, 0, 32'h100, 32'hDEADBEEF, 5'd3,  32'h0,        3, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 0);
    vecs[1]  = mk("lb",     1, 0, MEM_B, 0, 32'h103, 32'h0,        5'd7,  32'h80123456, 1, 1, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 1, 0);
    vecs[2]  = mk("lbu",    1, 0, MEM_B, 1, 32'h103, 32'h0,        5'd8,  32'h80123456, 2, 1, 32'h100, 4'b1000, 32'h0,        32'h00000080, 1, 0);
    vecs[3]  = mk("lh",     1, 0, MEM_H, 0, 32'h102, 32'h0,        5'd10, 32'h80123456, 1, 1, 32'h100, 4'b1100, 32'h0,        32'hFFFF8012, 1, 0);
    vecs[4]  = mk("sb",     0, 1, MEM_B, 0, 32'h101, 32'h000000AB, 5'd0,  32'h0,        1, 1, 32'h100, 4'b0010, 32'hABABABAB, 32'h0,        0, 0);
    vecs[5]  = mk("lw_mis", 1, 0, MEM_W, 0, 32'h102, 32'h0,        5'd11, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[6]  = mk("add",    0, 0, MEM_W, 0, 32'h1234,32'h0,        5'd5,  32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        32'h00001234, 1, 0);
    vecs[7]  = mk("lw",     1, 0, MEM_W, 0, 32'h200, 32'h0,        5'd9,  32'h11223344, 1, 1, 32'h200, 4'b1111, 32'h0,        32'h11223344, 1, 0);
    vecs[8]  = mk("lhu",    1, 0, MEM_H, 1, 32'h106, 32'h0,        5'd12, 32'h87654321, 4, 1, 32'h104, 4'b1100, 32'h0,        32'h00008765, 1, 0);
    vecs[9]  = mk("sh",     0, 1, MEM_H, 0, 32'h10A, 32'h0000CAFE, 5'd0,  32'h0,        2, 1, 32'h108, 4'b1100, 32'hCAFECAFE, 32'h0,        0, 0);
    vecs[10] = mk("lh_mis", 1, 0, MEM_H, 0, 32'h101, 32'h0,        5'd13, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0, 1);
    vecs[11] = mk("lb_pos", 1, 0, MEM_B, 0, 32'h100, 32'h0,        5'd3,  32'h0000007F, 1, 1, 32'h100, 4'b0001, 32'h0,        32'h0000007F, 1, 0);
    vecs[12] = mk("sb_b3",  0, 1, MEM_B, 0, 32'h103, 32'h12345699, 5'd0,  32'h0,        1, 1, 32'h100, 4'b1000, 32'h99999999, 32'h0,        0, 0);

    // Live aligned load presented during reset: nothing may happen.
    m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0; m_mem_size = MEM_W;
    m_mem_unsigned = 1'b0; m_alu_out = 32'h100; m_mem_data = 32'h0;
    m_rd = 5'd1; m_reg_write = 1'b1; bus.d_ack = 1'b0; bus.d_rdata = 32'h0;
    #22;
    chk("rst m_stall", {31'd0, m_stall}, 32'd0);
    chk("rst d_req", {31'd0, bus.d_req}, 32'd0);
    chk("rst d_we", {31'd0, bus.d_we}, 32'd0);
    chk("rst d_addr", bus.d_addr, 32'd0);
    chk("rst d_be", {28'd0, bus.d_be}, 32'd0);
    chk("rst d_wdata", bus.d_wdata, 32'd0);
    chk("rst w_data", w_data, 32'd0);
    chk("rst w_flags", {25'd0, w_rd, w_reg_write, w_valid, w_misaligned}, 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Bubbles with load strobes set and a stray ack while idle.
    @(negedge clk);
    m_valid = 1'b0; m_mem_read = 1'b1; bus.d_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ack d_req", {31'd0, bus.d_req}, 32'd0);
    chk("idle_ack m_stall", {31'd0, m_stall}, 32'd0);
    bus.d_ack = 1'b0;

    // Reset while a load is outstanding; the result must be dropped.
    @(negedge clk);
    m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0; m_mem_size = MEM_W;
    m_alu_out = 32'h300; m_rd = 5'd4;
    #1;
    chk("abort detect m_stall", {31'd0, m_stall}, 32'd1);
    @(negedge clk);
    chk("abort busy d_req", {31'd0, bus.d_req}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort d_req", {31'd0, bus.d_req}, 32'd0);
    chk("abort w_valid", {31'd0, w_valid}, 32'd0);
    chk("abort m_stall", {31'd0, m_stall}, 32'd0);
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk("lw_after_rst", 1, 0, MEM_W, 0, 32'h304, 32'h0, 5'd6, 32'hCAFEBABE, 1, 1,
             32'h304, 4'b1111, 32'h0, 32'hCAFEBABE, 1, 0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
